seq_array_mult: RTL

Parametrised, iterative successor to the team's combinational 4×4 array multiplier. Computes a 2·WIDTH-bit product one partial-product row per clock with a shift-add datapath, so area scales linearly with WIDTH instead of quadratically. Adds a per-operation signed/unsigned mode and valid/ready handshakes on both sides. Sits between the operand registers and the result consumer in the arithmetic datapath.

---
 rtl/seq_array_mult.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: one partial-product row per clock, 2*WIDTH-bit product.
// Signed mode multiplies magnitudes and negates the final sum; valid/ready on both sides.
module seq_array_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  input  logic                 is_signed,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_m;
  logic [WIDTH-1:0] mag_q;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] m_abs;
  logic [WIDTH-1:0] q_abs;
  logic             q_bit;
  logic [WIDTH:0]   row;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    result;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    m_abs = (is_signed && m[WIDTH-1]) ? WIDTH'(-m) : m;
    q_abs = (is_signed && q[WIDTH-1]) ? WIDTH'(-q) : q;
  end

  // Row add on the upper half with its carry kept, then the accumulator shifts right,
  // which is equivalent to adding mag_m << cnt into a fixed accumulator.
  always_comb begin
    q_bit    = mag_q[cnt];
    row      = {1'b0, acc[PW-1:WIDTH]} + (q_bit ? {1'b0, mag_m} : '0);
    acc_step = {row, acc[WIDTH-1:1]};
    result   = neg ? PW'(-acc_step) : acc_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      mag_m     <= '0;
      mag_q     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort outranks a simultaneous in_valid; otherwise it has no effect here
          if (in_valid && !abort) begin
            mag_m    <= m_abs;
            mag_q    <= q_abs;
            neg      <= is_signed && (m[WIDTH-1] ^ q[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              p         <= result;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
